switch_port_fifo: RTL and testbench

SWITCH_PORT_FIFO -- requirements
Module: switch_port_fifo

---
 rtl/switch_port_fifo.sv | 127 ++++++++++++
 tb/tb_switch_port_fifo.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_port_fifo.sv
// Switch-port ingress FIFO: drops illegal packets, buffers legal ones in a
// circular store, and presents them through a registered valid/ready egress stage.
`timescale 1ns/1ps

module switch_port_fifo #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             valid_in,
    output logic                             ready_in,
    input  logic [NUM_PORTS-1:0]             source_in,
    input  logic [NUM_PORTS-1:0]             target_in,
    input  logic [DATA_W-1:0]                data_in,
    output logic                             valid_out,
    input  logic                             ready_out,
    output logic [NUM_PORTS-1:0]             source_out,
    output logic [NUM_PORTS-1:0]             target_out,
    output logic [DATA_W-1:0]                data_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic [7:0]                       drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PKT_W = 2 * NUM_PORTS + DATA_W;

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    state_e               state_q, state_d;
    logic [PKT_W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [7:0]           drop_q, drop_d;
    logic [NUM_PORTS-1:0] source_q, target_q;
    logic [DATA_W-1:0]    data_q;

    logic full, empty, accept, src_onehot, legal, push, drop, pop;
    logic [PKT_W-1:0] head;

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);

    // Readiness looks only at stored occupancy, so a same-cycle pop never raises it.
    assign ready_in = !full && !rst;
    assign accept   = valid_in && ready_in;

    assign src_onehot = (source_in != '0) &&
                        ((source_in & (source_in - NUM_PORTS'(1))) == '0);
    assign legal = src_onehot && (target_in != '0) && ((target_in & source_in) == '0);
    assign push  = accept && legal;
    assign drop  = accept && !legal;
    assign head  = mem_q[rd_ptr_q];

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (ready_out) begin
                    if (!empty) pop = 1'b1;
                    else        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        drop_d = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            source_q <= '0;
            target_q <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            if (pop) {source_q, target_q, data_q} <= head;
        end
    end

    // NOTE: storage is deliberately left unreset; pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {source_in, target_in, data_in};
    end

    assign valid_out  = (state_q == SEND);
    assign source_out = source_q;
    assign target_out = target_q;
    assign data_out   = data_q;
    assign fifo_count = count_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_switch_port_fifo.sv
// Self-checking bench for switch_port_fifo: directed tables and sequences on the
// default build, a wide build for parametric checks, and a random run against a queue model.
`timescale 1ns/1ps

module tb_switch_port_fifo;

    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       valid_in, ready_in, valid_out, ready_out;
    logic [3:0] source_in, target_in, source_out, target_out;
    logic [7:0] data_in, data_out, drop_count;
    logic [2:0] fifo_count;

    logic        w_valid_in, w_ready_in, w_valid_out, w_ready_out;
    logic [7:0]  w_source_in, w_target_in, w_source_out, w_target_out, w_drop_count;
    logic [15:0] w_data_in, w_data_out;
    logic [3:0]  w_fifo_count;

    switch_port_fifo u_dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .ready_in(ready_in),
        .source_in(source_in), .target_in(target_in), .data_in(data_in),
        .valid_out(valid_out), .ready_out(ready_out),
        .source_out(source_out), .target_out(target_out), .data_out(data_out),
        .fifo_count(fifo_count), .drop_count(drop_count)
    );

    switch_port_fifo #(.NUM_PORTS(8), .DATA_W(16), .FIFO_DEPTH(8)) u_wide (
        .clk(clk), .rst(rst),
        .valid_in(w_valid_in), .ready_in(w_ready_in),
        .source_in(w_source_in), .target_in(w_target_in), .data_in(w_data_in),
        .valid_out(w_valid_out), .ready_out(w_ready_out),
        .source_out(w_source_out), .target_out(w_target_out), .data_out(w_data_out),
        .fifo_count(w_fifo_count), .drop_count(w_drop_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit is_legal(input logic [3:0] s, input logic [3:0] t);
        return ($countones(s) == 1) && (t != 4'd0) && ((s & t) == 4'd0);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        valid_in = 1'b0; ready_out = 1'b0;
        w_valid_in = 1'b0; w_ready_out = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0] src;
        logic [3:0] tgt;
        logic [7:0] data;
        bit         deliver;
        logic [7:0] drops;
    } vec_t;

    vec_t        vecs [7];
    logic [15:0] model_q [$];
    int          model_drops;
    bit          acc, seen;
    int          k, n_acc;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'b0001, 4'b0100, 8'hA5, 1'b1, 8'd0};
        vecs[1] = '{4'b0011, 4'b0100, 8'hB1, 1'b0, 8'd1};
        vecs[2] = '{4'b0001, 4'b0000, 8'hB2, 1'b0, 8'd2};
        vecs[3] = '{4'b0010, 4'b0010, 8'hB3, 1'b0, 8'd3};
        vecs[4] = '{4'b1000, 4'b0111, 8'hC4, 1'b1, 8'd3};
        vecs[5] = '{4'b0000, 4'b0001, 8'hB5, 1'b0, 8'd4};
        vecs[6] = '{4'b0100, 4'b1011, 8'hC6, 1'b1, 8'd4};

        rst = 1'b1;
        valid_in = 1'b0; ready_out = 1'b0; source_in = '0; target_in = '0; data_in = '0;
        w_valid_in = 1'b0; w_ready_out = 1'b0; w_source_in = '0; w_target_in = '0; w_data_in = '0;

        // Reset state before any clock edge.
        #3;
        check("rst_valid_out", valid_out, 0);
        check("rst_ready_in", ready_in, 0);
        check("rst_outs", {source_out, target_out, data_out}, 0);
        check("rst_counts", {fifo_count, drop_count}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready_in", ready_in, 1);

        // Single packet latency and release.
        ready_out = 1'b1;
        valid_in = 1'b1; source_in = 4'b0001; target_in = 4'b0100; data_in = 8'hA5;
        @(negedge clk);
        valid_in = 1'b0;
        check("single_not_yet", {valid_out, fifo_count}, {1'b0, 3'd1});
        @(negedge clk);
        check("single_out", {valid_out, source_out, target_out, data_out}, {1'b1, 4'b0001, 4'b0100, 8'hA5});
        check("single_count", fifo_count, 0);
        @(negedge clk);
        check("single_release", {valid_out, data_out}, {1'b0, 8'hA5});

        // Legality table.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            seen = 1'b0;
            check($sformatf("tbl%0d_ready", i), ready_in, 1);
            ready_out = 1'b1;
            valid_in = 1'b1; source_in = vecs[i].src; target_in = vecs[i].tgt; data_in = vecs[i].data;
            @(negedge clk);
            valid_in = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (valid_out && source_out == vecs[i].src && target_out == vecs[i].tgt &&
                    data_out == vecs[i].data)
                    seen = 1'b1;
            end
            check($sformatf("tbl%0d_deliver", i), seen, vecs[i].deliver);
            check($sformatf("tbl%0d_drops", i), drop_count, vecs[i].drops);
        end

        // Drop counter saturation.
        do_reset();
        valid_in = 1'b1; source_in = 4'b0011; target_in = 4'b0100; data_in = 8'h00;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (i == 254) check("sat_254", drop_count, 254);
            if (i == 255) check("sat_255", drop_count, 255);
        end
        check("sat_300", drop_count, 255);
        repeat (5) @(negedge clk);
        valid_in = 1'b0;
        check("sat_hold", drop_count, 255);
        check("sat_nothing_stored", {valid_out, fifo_count}, 0);

        // Fill under backpressure, then back-to-back drain.
        do_reset();
        ready_out = 1'b0;
        k = 0;
        for (int guard = 0; guard < 20 && k < 5; guard++) begin
            valid_in = 1'b1; source_in = 4'b0001; target_in = 4'b1110; data_in = 8'h10 + 8'(k);
            acc = ready_in;
            @(negedge clk);
            if (acc) k++;
        end
        check("fill_accepted", k, 5);
        data_in = 8'h15;
        repeat (2) @(negedge clk);
        check("fill_count", fifo_count, 4);
        check("fill_ready_in", ready_in, 0);
        check("fill_head", {valid_out, target_out, data_out}, {1'b1, 4'b1110, 8'h10});
        ready_out = 1'b1;
        for (int j = 0; j < 6; j++) begin
            check($sformatf("drain%0d", j), {valid_out, data_out}, {1'b1, 8'h10 + 8'(j)});
            acc = valid_in && ready_in;
            @(negedge clk);
            if (acc) valid_in = 1'b0;
        end
        check("drain_done", {valid_out, fifo_count, valid_in}, 0);

        // Reset asserted mid-transfer.
        do_reset();
        ready_out = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1; source_in = 4'b0010; target_in = 4'b0001; data_in = 8'h20 + 8'(i);
            @(negedge clk);
        end
        valid_in = 1'b0;
        check("mid_pre", {valid_out, fifo_count}, {1'b1, 3'd3});
        #2 rst = 1'b1;
        #1;
        check("mid_outs_zero", {valid_out, source_out, target_out, data_out}, 0);
        check("mid_counts_zero", {fifo_count, ready_in}, 0);
        #4 rst = 1'b0;
        @(negedge clk);
        check("mid_ready_after", ready_in, 1);
        ready_out = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (valid_out) seen = 1'b1;
        end
        check("mid_no_stale", seen, 0);

        // Wide build: intact delivery and full depth of 8.
        do_reset();
        w_ready_out = 1'b0;
        w_valid_in = 1'b1; w_source_in = 8'h80; w_target_in = 8'h7F; w_data_in = 16'hBEEF;
        n_acc = 0;
        for (int guard = 0; guard < 20 && w_ready_in; guard++) begin
            acc = w_ready_in;
            @(negedge clk);
            if (acc) begin
                n_acc++;
                w_source_in = 8'h01; w_target_in = 8'hFE; w_data_in = 16'h1000 + 16'(n_acc);
            end
        end
        w_valid_in = 1'b0;
        check("wide_accepted", n_acc, 9);
        check("wide_count", w_fifo_count, 8);
        check("wide_head", {w_valid_out, w_source_out, w_target_out, w_data_out},
              {1'b1, 8'h80, 8'h7F, 16'hBEEF});
        w_ready_out = 1'b1;
        @(negedge clk);
        for (int j = 1; j < 9; j++) begin
            check($sformatf("wide_drain%0d", j), {w_valid_out, w_data_out}, {1'b1, 16'h1000 + 16'(j)});
            @(negedge clk);
        end
        check("wide_done", {w_valid_out, w_fifo_count}, 0);

        // Random traffic against a queue model of packets in flight.
        do_reset();
        model_q.delete();
        model_drops = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (valid_out) begin
                if (model_q.size() == 0) check("rnd_spurious", 1, 0);
                else check("rnd_head", {source_out, target_out, data_out}, model_q[0]);
            end
            check("rnd_count", int'(fifo_count) + int'(valid_out), model_q.size());
            check("rnd_drops", drop_count, model_drops);
            check("rnd_ready", ready_in, (model_q.size() - int'(valid_out)) < FD);
            valid_in  = ($urandom_range(0, 9) < 7);
            source_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            target_in = 4'($urandom);
            data_in   = 8'($urandom);
            ready_out = ($urandom_range(0, 9) < 6);
            if (valid_out && ready_out && model_q.size() > 0) void'(model_q.pop_front());
            if (valid_in && ready_in) begin
                if (is_legal(source_in, target_in)) model_q.push_back({source_in, target_in, data_in});
                else if (model_drops < 255) model_drops++;
            end
            @(negedge clk);
        end
        valid_in = 1'b0;
        ready_out = 1'b1;
        for (int guard = 0; guard < 20 && (model_q.size() > 0 || valid_out); guard++) begin
            if (valid_out) begin
                if (model_q.size() == 0) check("rnd_drain_spurious", 1, 0);
                else begin
                    check("rnd_drain_head", {source_out, target_out, data_out}, model_q[0]);
                    void'(model_q.pop_front());
                end
            end
            @(negedge clk);
        end
        check("rnd_drain_empty", model_q.size(), 0);
        check("rnd_drain_idle", {valid_out, fifo_count}, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
